// File: rtl/asrm_ram_mmio_pkg.sv
// Shared constants and types for the RAM + MMIO block: window offsets, timer ctrl bit
// positions and the decoded MMIO write-strobe bundle.
package asrm_ram_mmio_pkg;

  localparam logic [3:0] mmio_gpio_out     = 4'd0;
  localparam logic [3:0] mmio_gpio_in      = 4'd1;
  localparam logic [3:0] mmio_timer_count  = 4'd2;
  localparam logic [3:0] mmio_timer_reload = 4'd3;
  localparam logic [3:0] mmio_timer_ctrl   = 4'd4;

  localparam int unsigned tctrl_en   = 0;
  localparam int unsigned tctrl_auto = 1;
  localparam int unsigned tctrl_flag = 2;

  typedef struct packed {
    logic ram;
    logic gpio_out;
    logic count;
    logic reload;
    logic ctrl;
  } mmio_we_t;

  // Writes to read-only or unmapped window offsets produce no strobe at all.
  function automatic mmio_we_t decode_we(input logic in_mmio, input logic [3:0] off,
                                         input logic we);
    mmio_we_t s;
    s          = '0;
    s.ram      = we & ~in_mmio;
    s.gpio_out = we & in_mmio & (off == mmio_gpio_out);
    s.count    = we & in_mmio & (off == mmio_timer_count);
    s.reload   = we & in_mmio & (off == mmio_timer_reload);
    s.ctrl     = we & in_mmio & (off == mmio_timer_ctrl);
    return s;
  endfunction

endpackage

// File: rtl/asrm_mmio_timer.sv
// Down-counting timer with reload, one-shot/auto-reload control and a sticky flag.
// CPU writes take priority over the hardware count/reload/disable behaviour.
module asrm_mmio_timer
  import asrm_ram_mmio_pkg::*;
#(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             count_we_i,
  input  logic             reload_we_i,
  input  logic             ctrl_we_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] count_o,
  output logic [Width-1:0] reload_o,
  output logic [Width-1:0] ctrl_o,
  output logic             flag_o
);

  logic [Width-1:0] count_q, count_d;
  logic [Width-1:0] reload_q, reload_d;
  logic             en_q, en_d;
  logic             auto_q, auto_d;
  logic             flag_q, flag_d;
  logic             flag_set;

  always_comb begin
    count_d  = count_q;
    reload_d = reload_q;
    en_d     = en_q;
    auto_d   = auto_q;
    flag_set = 1'b0;

    if (en_q) begin
      if (count_q != '0) begin
        count_d = count_q - Width'(1);
      end else begin
        flag_set = 1'b1;
        if (auto_q) begin
          count_d = reload_q;
        end else begin
          en_d = 1'b0;
        end
      end
    end

    if (count_we_i) begin
      count_d = wdata_i;
    end
    if (reload_we_i) begin
      reload_d = wdata_i;
    end
    // A ctrl write overrides this cycle's one-shot auto-disable.
    if (ctrl_we_i) begin
      en_d   = wdata_i[tctrl_en];
      auto_d = wdata_i[tctrl_auto];
    end

    // Hardware set beats a same-cycle write-1-to-clear.
    flag_d = flag_set | (flag_q & ~(ctrl_we_i & wdata_i[tctrl_flag]));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q  <= '0;
      reload_q <= '0;
      en_q     <= 1'b0;
      auto_q   <= 1'b0;
      flag_q   <= 1'b0;
    end else begin
      count_q  <= count_d;
      reload_q <= reload_d;
      en_q     <= en_d;
      auto_q   <= auto_d;
      flag_q   <= flag_d;
    end
  end

  always_comb begin
    ctrl_o             = '0;
    ctrl_o[tctrl_en]   = en_q;
    ctrl_o[tctrl_auto] = auto_q;
    ctrl_o[tctrl_flag] = flag_q;
  end

  assign count_o  = count_q;
  assign reload_o = reload_q;
  assign flag_o   = flag_q;

endmodule

// File: rtl/asrm_ram_mmio.sv
// Word RAM plus a 16-word MMIO window (GPIO and timer) at the top of the address space.
// Reads are registered every cycle (1-clock latency); the RAM is read-first.
module asrm_ram_mmio
  import asrm_ram_mmio_pkg::*;
#(
  parameter int unsigned            wordsize       = 16,
  parameter int unsigned            ram_depth_log2 = 8,
  parameter logic [wordsize-1:0]    mmio_base      = {{(wordsize - 4){1'b1}}, 4'b0000}
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [wordsize-1:0] addr,
  input  logic [wordsize-1:0] wr_data,
  input  logic                write_en,
  output logic [wordsize-1:0] rd_data,
  input  logic [wordsize-1:0] gpio_in,
  output logic [wordsize-1:0] gpio_out,
  output logic                timer_irq
);

  localparam int unsigned RamDepth = 2 ** ram_depth_log2;

  logic [wordsize-1:0]       mem_q [RamDepth];
  logic [wordsize-1:0]       rd_data_q, rd_data_d;
  logic [wordsize-1:0]       gpio_out_q, gpio_out_d;
  logic [wordsize-1:0]       gpio_s1_q, gpio_s2_q;
  logic                      in_mmio;
  logic [3:0]                off;
  logic [ram_depth_log2-1:0] ram_idx;
  mmio_we_t                  we;

  logic [wordsize-1:0] t_count, t_reload, t_ctrl;
  logic                t_flag;

  assign in_mmio = (addr[wordsize-1:4] == mmio_base[wordsize-1:4]);
  assign off     = addr[3:0];
  // Upper address bits are ignored, so the RAM aliases across the address space.
  assign ram_idx = addr[ram_depth_log2-1:0];
  assign we      = decode_we(in_mmio, off, write_en);

  asrm_mmio_timer #(
    .Width(wordsize)
  ) u_timer (
    .clk_i      (clk),
    .rst_i      (reset),
    .count_we_i (we.count),
    .reload_we_i(we.reload),
    .ctrl_we_i  (we.ctrl),
    .wdata_i    (wr_data),
    .count_o    (t_count),
    .reload_o   (t_reload),
    .ctrl_o     (t_ctrl),
    .flag_o     (t_flag)
  );

  // Array has no reset; a write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (we.ram && !reset) begin
      mem_q[ram_idx] <= wr_data;
    end
  end

  always_comb begin
    gpio_out_d = gpio_out_q;
    if (we.gpio_out) begin
      gpio_out_d = wr_data;
    end
  end

  always_comb begin
    rd_data_d = mem_q[ram_idx];
    if (in_mmio) begin
      case (off)
        mmio_gpio_out:     rd_data_d = gpio_out_q;
        mmio_gpio_in:      rd_data_d = gpio_s2_q;
        mmio_timer_count:  rd_data_d = t_count;
        mmio_timer_reload: rd_data_d = t_reload;
        mmio_timer_ctrl:   rd_data_d = t_ctrl;
        default:           rd_data_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_q  <= '0;
      gpio_out_q <= '0;
      gpio_s1_q  <= '0;
      gpio_s2_q  <= '0;
    end else begin
      rd_data_q  <= rd_data_d;
      gpio_out_q <= gpio_out_d;
      gpio_s1_q  <= gpio_in;
      gpio_s2_q  <= gpio_s1_q;
    end
  end

  assign rd_data   = rd_data_q;
  assign gpio_out  = gpio_out_q;
  assign timer_irq = t_flag;

endmodule

// File: tb/tb_asrm_ram_mmio.sv
// Directed bench for asrm_ram_mmio: RAM read/write, MMIO GPIO, timer and async reset.
module tb_asrm_ram_mmio;

  localparam logic [15:0] Base = 16'hFFF0;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] addr;
  logic [15:0] wr_data;
  logic        write_en;
  logic [15:0] rd_data;
  logic [15:0] gpio_in;
  logic [15:0] gpio_out;
  logic        timer_irq;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [15:0] exp_q[$];

  asrm_ram_mmio dut (
    .clk      (clk),
    .reset    (reset),
    .addr     (addr),
    .wr_data  (wr_data),
    .write_en (write_en),
    .rd_data  (rd_data),
    .gpio_in  (gpio_in),
    .gpio_out (gpio_out),
    .timer_irq(timer_irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    addr     = a;
    wr_data  = d;
    write_en = 1'b1;
    tick();
    write_en = 1'b0;
  endtask

  // Expected value queued when the address is driven, compared when rd_data updates.
  task automatic rd(input string tag, input logic [15:0] a, input logic [15:0] exp);
    logic [15:0] e;
    addr     = a;
    write_en = 1'b0;
    exp_q.push_back(exp);
    tick();
    e = exp_q.pop_front();
    check(tag, rd_data, e);
  endtask

  initial begin
    reset    = 1'b1;
    addr     = '0;
    wr_data  = '0;
    write_en = 1'b0;
    gpio_in  = '0;
    repeat (2) tick();
    check("reset_rd_data", rd_data, 16'h0000);
    check("reset_gpio_out", gpio_out, 16'h0000);
    check("reset_irq", {15'b0, timer_irq}, 16'h0000);
    reset = 1'b0;
    tick();

    // RAM basic, read-first, aliasing
    wr(16'd5, 16'h1234);
    rd("ram_rd5", 16'd5, 16'h1234);
    wr(16'd3, 16'h0001);
    addr     = 16'd3;
    wr_data  = 16'hAAAA;
    write_en = 1'b1;
    exp_q.push_back(16'h0001);
    tick();
    write_en = 1'b0;
    check("ram_read_first", rd_data, exp_q.pop_front());
    rd("ram_after_write", 16'd3, 16'hAAAA);
    wr(16'h0107, 16'hBEEF);
    rd("ram_alias_7", 16'd7, 16'hBEEF);
    wr(16'h0100, 16'h0C0C);
    rd("ram_alias_0", 16'd0, 16'h0C0C);

    // GPIO
    wr(Base + 16'd0, 16'h00F0);
    check("gpio_out_pin", gpio_out, 16'h00F0);
    rd("gpio_out_rd", Base + 16'd0, 16'h00F0);
    gpio_in = 16'h5A5A;
    addr    = Base + 16'd1;
    for (int k = 1; k <= 3; k++) begin
      exp_q.push_back((k == 3) ? 16'h5A5A : 16'h0000);
      tick();
      check($sformatf("gpio_in_edge%0d", k), rd_data, exp_q.pop_front());
    end
    wr(Base + 16'd1, 16'hFFFF);
    rd("gpio_in_ro", Base + 16'd1, 16'h5A5A);
    rd("mmio_unmapped", Base + 16'd9, 16'h0000);
    rd("ram_not_shadowed", 16'd5, 16'h1234);

    // Auto-reload timer: period reload+1 = 4
    wr(Base + 16'd3, 16'd3);
    wr(Base + 16'd2, 16'd3);
    wr(Base + 16'd4, 16'h0003);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check($sformatf("tmr_auto_e%0d", k), {15'b0, timer_irq}, (k == 4) ? 16'd1 : 16'd0);
    end
    wr(Base + 16'd4, 16'h0007);
    check("tmr_clear", {15'b0, timer_irq}, 16'd0);
    for (int k = 2; k <= 4; k++) begin
      tick();
      check($sformatf("tmr_repeat_e%0d", k), {15'b0, timer_irq}, (k == 4) ? 16'd1 : 16'd0);
    end
    repeat (3) tick();
    wr(Base + 16'd4, 16'h0007);
    check("tmr_set_wins", {15'b0, timer_irq}, 16'd1);
    rd("tmr_ctrl_rd", Base + 16'd4, 16'h0007);

    // One-shot timer
    wr(Base + 16'd4, 16'h0004);
    check("tmr_disable_clear", {15'b0, timer_irq}, 16'd0);
    wr(Base + 16'd2, 16'd2);
    wr(Base + 16'd4, 16'h0001);
    for (int k = 1; k <= 3; k++) begin
      tick();
      check($sformatf("tmr_oneshot_e%0d", k), {15'b0, timer_irq}, (k == 3) ? 16'd1 : 16'd0);
    end
    rd("tmr_oneshot_ctrl", Base + 16'd4, 16'h0004);
    tick();
    rd("tmr_oneshot_count", Base + 16'd2, 16'h0000);
    rd("tmr_reload_rd", Base + 16'd3, 16'h0003);

    // Asynchronous reset in the middle of a GPIO write
    addr     = Base + 16'd0;
    wr_data  = 16'hFFFF;
    write_en = 1'b1;
    #3;
    reset = 1'b1;
    #1;
    check("arst_gpio_out", gpio_out, 16'h0000);
    check("arst_irq", {15'b0, timer_irq}, 16'h0000);
    check("arst_rd_data", rd_data, 16'h0000);
    tick();
    check("arst_gpio_hold", gpio_out, 16'h0000);
    reset    = 1'b0;
    write_en = 1'b0;
    rd("arst_gpio_rd", Base + 16'd0, 16'h0000);
    rd("arst_reload_rd", Base + 16'd3, 16'h0000);
    rd("arst_ctrl_rd", Base + 16'd4, 16'h0000);
    rd("arst_ram_kept", 16'd5, 16'h1234);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
